// File: rtl/impl_window_chk_pkg.sv
// Shared types and helpers for the implication-window checker.
// One channel times the consequent window after each accepted antecedent.
package impl_window_chk_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } chk_state_e;

  // Counters are carried through this helper at 32 bits and truncated by the caller.
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic [31:0] vmax);
    return (v >= vmax) ? vmax : v + 32'd1;
  endfunction

  function automatic int dly_width(input int max_dly);
    return (max_dly < 1) ? 1 : $clog2(max_dly + 1);
  endfunction

  function automatic bit params_ok(input int num_ch, input int min_dly,
                                   input int max_dly, input int cnt_w);
    return (num_ch >= 1) && (min_dly >= 0) && (max_dly >= min_dly) &&
           (cnt_w >= 1) && (cnt_w <= 32);
  endfunction

endpackage

// File: rtl/impl_window_chk_chan.sv
// One checker channel: IDLE/WAIT FSM, offset counter, registered pulses,
// sticky error flag and two saturating event counters.
module impl_window_chk_chan
  import impl_window_chk_pkg::*;
#(
  parameter int MIN_DLY    = 1,
  parameter int MAX_DLY    = 4,
  parameter int EARLY_FAIL = 0,
  parameter int CNT_W      = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  input  logic             a,
  input  logic             b,
  output logic             pass_o,
  output logic             fail_o,
  output logic             err_sticky,
  output logic             busy_o,
  output logic [CNT_W-1:0] fail_cnt,
  output logic [CNT_W-1:0] ovl_cnt
);

  localparam int          DW      = dly_width(MAX_DLY);
  localparam logic [31:0] CNT_MAX = 32'((64'd1 << CNT_W) - 64'd1);

  chk_state_e    state, state_nxt;
  logic [DW-1:0] dly, dly_nxt;
  logic          pass_nxt, fail_nxt, ovl_hit;
  int            off;

  assign off    = 32'(dly);
  assign busy_o = (state == WAIT);

  always_comb begin
    state_nxt = state;
    dly_nxt   = dly;
    pass_nxt  = 1'b0;
    fail_nxt  = 1'b0;
    ovl_hit   = 1'b0;
    case (state)
      IDLE: begin
        if (en && a) begin
          if (MIN_DLY == 0 && b) begin
            pass_nxt = 1'b1;
          end else if (MAX_DLY == 0) begin
            // A zero-width window at offset 0 with b low can only fail.
            fail_nxt = 1'b1;
          end else begin
            state_nxt = WAIT;
            dly_nxt   = DW'(1);
          end
        end
      end
      WAIT: begin
        if (!en) begin
          state_nxt = IDLE;
          dly_nxt   = '0;
        end else begin
          ovl_hit = a;
          if (b && off >= MIN_DLY) begin
            pass_nxt = 1'b1;
          end else if (b && EARLY_FAIL != 0) begin
            fail_nxt = 1'b1;
          end else if (off >= MAX_DLY) begin
            fail_nxt = 1'b1;
          end else begin
            dly_nxt = dly + DW'(1);
          end
          if (pass_nxt || fail_nxt) begin
            state_nxt = IDLE;
            dly_nxt   = '0;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
        dly_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      dly        <= '0;
      pass_o     <= 1'b0;
      fail_o     <= 1'b0;
      err_sticky <= 1'b0;
      fail_cnt   <= '0;
      ovl_cnt    <= '0;
    end else begin
      state  <= state_nxt;
      dly    <= dly_nxt;
      pass_o <= pass_nxt;
      fail_o <= fail_nxt;
      // clr overrides a coincident failure for the flag and counters; the pulse still fires.
      if (clr) begin
        err_sticky <= 1'b0;
        fail_cnt   <= '0;
        ovl_cnt    <= '0;
      end else begin
        if (fail_nxt) begin
          err_sticky <= 1'b1;
          fail_cnt   <= CNT_W'(sat_inc(32'(fail_cnt), CNT_MAX));
        end
        if (ovl_hit) begin
          ovl_cnt <= CNT_W'(sat_inc(32'(ovl_cnt), CNT_MAX));
        end
      end
    end
  end

endmodule

// File: rtl/impl_window_chk.sv
// Multi-channel runtime checker for a |-> ##[MIN_DLY:MAX_DLY] b.
// Each channel is an independent impl_window_chk_chan; outputs are packed per channel.
module impl_window_chk
  import impl_window_chk_pkg::*;
#(
  parameter int NUM_CH     = 4,
  parameter int MIN_DLY    = 1,
  parameter int MAX_DLY    = 4,
  parameter int EARLY_FAIL = 0,
  parameter int CNT_W      = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_CH-1:0]       en,
  input  logic                    clr,
  input  logic [NUM_CH-1:0]       a,
  input  logic [NUM_CH-1:0]       b,
  output logic [NUM_CH-1:0]       pass_o,
  output logic [NUM_CH-1:0]       fail_o,
  output logic [NUM_CH-1:0]       err_sticky,
  output logic [NUM_CH-1:0]       busy_o,
  output logic [NUM_CH*CNT_W-1:0] fail_cnt,
  output logic [NUM_CH*CNT_W-1:0] ovl_cnt
);

  if (!params_ok(NUM_CH, MIN_DLY, MAX_DLY, CNT_W)) begin : g_bad_params
    $error("impl_window_chk: illegal parameters (need NUM_CH>=1, 0<=MIN_DLY<=MAX_DLY, 1<=CNT_W<=32)");
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    impl_window_chk_chan #(
      .MIN_DLY    (MIN_DLY),
      .MAX_DLY    (MAX_DLY),
      .EARLY_FAIL (EARLY_FAIL),
      .CNT_W      (CNT_W)
    ) u_chan (
      .clk        (clk),
      .rst_n      (rst_n),
      .en         (en[i]),
      .clr        (clr),
      .a          (a[i]),
      .b          (b[i]),
      .pass_o     (pass_o[i]),
      .fail_o     (fail_o[i]),
      .err_sticky (err_sticky[i]),
      .busy_o     (busy_o[i]),
      .fail_cnt   (fail_cnt[i*CNT_W +: CNT_W]),
      .ovl_cnt    (ovl_cnt[i*CNT_W +: CNT_W])
    );
  end

endmodule

// File: tb/tb_impl_window_chk.sv
// Bench for impl_window_chk: four parameterisations driven by shared stimulus,
// checked every cycle against a timestamp-based window model plus literal spot checks.
module tb_impl_window_chk;

  logic       clk, rst_n, clr;
  logic [3:0] en, a, b;

  logic [3:0]  pso [4];
  logic [3:0]  flo [4];
  logic [3:0]  ers [4];
  logic [3:0]  bso [4];
  logic [7:0]  fc0, oc0;
  logic [31:0] fc1, oc1, fc2, oc2, fc3, oc3;

  int checks = 0;
  int errors = 0;

  // Instance parameter sets: 0 main (CNT_W=2), 1 early-fail, 2 zero window, 3 MIN=2 no early-fail
  int MINv [4] = '{1, 2, 0, 2};
  int MAXv [4] = '{4, 4, 0, 4};
  int EFv  [4] = '{0, 1, 0, 0};
  int CMX  [4] = '{3, 255, 255, 255};
  int CW   [4] = '{2, 8, 8, 8};

  impl_window_chk #(.NUM_CH(4), .MIN_DLY(1), .MAX_DLY(4), .EARLY_FAIL(0), .CNT_W(2)) u_a (
    .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .a(a), .b(b),
    .pass_o(pso[0]), .fail_o(flo[0]), .err_sticky(ers[0]), .busy_o(bso[0]),
    .fail_cnt(fc0), .ovl_cnt(oc0));
  impl_window_chk #(.NUM_CH(4), .MIN_DLY(2), .MAX_DLY(4), .EARLY_FAIL(1), .CNT_W(8)) u_b (
    .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .a(a), .b(b),
    .pass_o(pso[1]), .fail_o(flo[1]), .err_sticky(ers[1]), .busy_o(bso[1]),
    .fail_cnt(fc1), .ovl_cnt(oc1));
  impl_window_chk #(.NUM_CH(4), .MIN_DLY(0), .MAX_DLY(0), .EARLY_FAIL(0), .CNT_W(8)) u_c (
    .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .a(a), .b(b),
    .pass_o(pso[2]), .fail_o(flo[2]), .err_sticky(ers[2]), .busy_o(bso[2]),
    .fail_cnt(fc2), .ovl_cnt(oc2));
  impl_window_chk #(.NUM_CH(4), .MIN_DLY(2), .MAX_DLY(4), .EARLY_FAIL(0), .CNT_W(8)) u_d (
    .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .a(a), .b(b),
    .pass_o(pso[3]), .fail_o(flo[3]), .err_sticky(ers[3]), .busy_o(bso[3]),
    .fail_cnt(fc3), .ovl_cnt(oc3));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Model: an attempt is a timestamp; its offset is edges elapsed since the trigger.
  int m_busy [4][4];
  int m_t0   [4][4];
  int m_pass [4][4];
  int m_fail [4][4];
  int m_err  [4][4];
  int m_fc   [4][4];
  int m_oc   [4][4];
  int cyc = 0;

  initial begin : model
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        cyc = 0;
        for (int i = 0; i < 4; i++)
          for (int c = 0; c < 4; c++) begin
            m_busy[i][c] = 0; m_t0[i][c] = 0; m_pass[i][c] = 0; m_fail[i][c] = 0;
            m_err[i][c] = 0; m_fc[i][c] = 0; m_oc[i][c] = 0;
          end
      end else begin
        for (int i = 0; i < 4; i++)
          for (int c = 0; c < 4; c++) begin
            int  off;
            bit  act, ps, fl, ov;
            act = 0; ps = 0; fl = 0; ov = 0; off = 0;
            if (m_busy[i][c] == 0) begin
              if (en[c] && a[c]) begin act = 1; off = 0; m_t0[i][c] = cyc; end
            end else if (!en[c]) begin
              m_busy[i][c] = 0;
            end else begin
              act = 1; off = cyc - m_t0[i][c]; ov = a[c];
            end
            if (act) begin
              if (b[c] && off >= MINv[i] && off <= MAXv[i]) ps = 1;
              else if (b[c] && off > 0 && off < MINv[i] && EFv[i] != 0) fl = 1;
              else if (off >= MAXv[i]) fl = 1;
              m_busy[i][c] = (ps || fl) ? 0 : 1;
            end
            m_pass[i][c] = ps;
            m_fail[i][c] = fl;
            if (clr) begin
              m_err[i][c] = 0; m_fc[i][c] = 0; m_oc[i][c] = 0;
            end else begin
              if (fl) begin
                m_err[i][c] = 1;
                if (m_fc[i][c] < CMX[i]) m_fc[i][c]++;
              end
              if (ov && m_oc[i][c] < CMX[i]) m_oc[i][c]++;
            end
          end
        cyc++;
      end
    end
  end

  initial begin : compare
    forever begin
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
        logic [3:0]  ep, ef, eb, ee;
        logic [31:0] efc, eoc, afc, aoc;
        ep = '0; ef = '0; eb = '0; ee = '0; efc = '0; eoc = '0;
        for (int c = 0; c < 4; c++) begin
          ep[c] = (m_pass[i][c] != 0);
          ef[c] = (m_fail[i][c] != 0);
          eb[c] = (m_busy[i][c] != 0);
          ee[c] = (m_err[i][c] != 0);
          efc = efc | (32'(m_fc[i][c]) << (CW[i] * c));
          eoc = eoc | (32'(m_oc[i][c]) << (CW[i] * c));
        end
        case (i)
          0:       begin afc = 32'(fc0); aoc = 32'(oc0); end
          1:       begin afc = fc1; aoc = oc1; end
          2:       begin afc = fc2; aoc = oc2; end
          default: begin afc = fc3; aoc = oc3; end
        endcase
        chk($sformatf("inst%0d pass_o", i), 32'(pso[i]), 32'(ep));
        chk($sformatf("inst%0d fail_o", i), 32'(flo[i]), 32'(ef));
        chk($sformatf("inst%0d busy_o", i), 32'(bso[i]), 32'(eb));
        chk($sformatf("inst%0d err_sticky", i), 32'(ers[i]), 32'(ee));
        chk($sformatf("inst%0d fail_cnt", i), afc, efc);
        chk($sformatf("inst%0d ovl_cnt", i), aoc, eoc);
      end
    end
  end

  task automatic tick(input logic [3:0] e, input logic [3:0] aa, input logic [3:0] bb,
                      input logic c);
    en = e; a = aa; b = bb; clr = c;
    @(posedge clk);
    #1;
  endtask

  initial begin : stim
    int nf;
    rst_n = 1'b0; en = '0; a = '0; b = '0; clr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst busy", 32'(bso[0]), 32'h0);
    chk("rst fail_cnt", 32'(fc0), 32'h0);
    chk("rst err_sticky", 32'(ers[0]), 32'h0);
    rst_n = 1'b1;

    // ch0 passes at offset 3; ch1 never sees b and fails at offset 4
    tick(4'hF, 4'b0011, 4'b0000, 1'b0);
    chk("t1 busy after trigger", 32'(bso[0]), 32'h3);
    tick(4'hF, 4'b0000, 4'b0000, 1'b0);
    tick(4'hF, 4'b0000, 4'b0000, 1'b0);
    tick(4'hF, 4'b0000, 4'b0001, 1'b0);
    chk("t1 pass ch0", 32'(pso[0]), 32'h1);
    chk("t1 fail_cnt ch0", 32'(fc0), 32'h0);
    tick(4'hF, 4'b0000, 4'b0000, 1'b0);
    chk("t1 fail ch1", 32'(flo[0]), 32'h2);
    chk("t1 err ch1", 32'(ers[0]), 32'h2);
    chk("t1 fail_cnt ch1", 32'(fc0), 32'h4);
    chk("t1 busy clear", 32'(bso[0]), 32'h0);
    tick(4'hF, 4'b0000, 4'b0000, 1'b0);

    // early b on ch2: fail with EARLY_FAIL=1, ignored with EARLY_FAIL=0
    tick(4'hF, 4'b0100, 4'b0000, 1'b0);
    tick(4'hF, 4'b0000, 4'b0100, 1'b0);
    chk("ef early fail", 32'(flo[1]), 32'h4);
    chk("ef min1 pass", 32'(pso[0]), 32'h4);
    chk("ef0 no pulse", 32'({pso[3], flo[3]}), 32'h0);
    tick(4'hF, 4'b0000, 4'b0000, 1'b0);
    tick(4'hF, 4'b0000, 4'b0100, 1'b0);
    chk("ef0 pass off3", 32'(pso[3]), 32'h4);
    chk("ef idle ignores b", 32'(pso[1]), 32'h0);

    // zero-width window on ch3
    tick(4'hF, 4'b1000, 4'b1000, 1'b0);
    chk("zero pass", 32'(pso[2]), 32'h8);
    tick(4'hF, 4'b1000, 4'b0000, 1'b0);
    chk("zero fail", 32'(flo[2]), 32'h8);
    chk("zero no pass", 32'(pso[2]), 32'h0);
    repeat (5) tick(4'hF, 4'b0000, 4'b0000, 1'b0);

    // a held high: fails every 5 edges, overlap and failure counters saturate at 3
    tick(4'hF, 4'b0000, 4'b0000, 1'b1);
    nf = 0;
    for (int k = 0; k < 20; k++) begin
      tick(4'hF, 4'b0001, 4'b0000, 1'b0);
      if (flo[0][0]) nf++;
    end
    chk("hold fail pulses", 32'(nf), 32'd4);
    chk("hold ovl_cnt sat", 32'(oc0[1:0]), 32'd3);
    chk("hold fail_cnt sat", 32'(fc0[1:0]), 32'd3);
    tick(4'hF, 4'b0000, 4'b0000, 1'b0);

    // reset in the middle of a wait
    tick(4'hF, 4'b0010, 4'b0000, 1'b0);
    tick(4'hF, 4'b0000, 4'b0000, 1'b0);
    #2 rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("rst mid busy", 32'(bso[0]), 32'h0);
    chk("rst mid pulses", 32'({pso[0], flo[0]}), 32'h0);
    rst_n = 1'b1;
    tick(4'hF, 4'b0010, 4'b0000, 1'b0);
    tick(4'hF, 4'b0000, 4'b0000, 1'b0);
    tick(4'hF, 4'b0000, 4'b0010, 1'b0);
    chk("post rst pass", 32'(pso[0]), 32'h2);

    // disable in the middle of a wait
    tick(4'hF, 4'b0100, 4'b0000, 1'b0);
    tick(4'hF, 4'b0000, 4'b0000, 1'b0);
    tick(4'b1011, 4'b0000, 4'b0000, 1'b0);
    chk("en drop busy", 32'(bso[0]), 32'h0);
    chk("en drop pulses", 32'({pso[0], flo[0]}), 32'h0);
    nf = 0;
    for (int k = 0; k < 5; k++) begin
      tick(4'hF, 4'b0000, 4'b0000, 1'b0);
      if (flo[0][2]) nf++;
    end
    chk("en drop no late fail", 32'(nf), 32'd0);
    tick(4'hF, 4'b0100, 4'b0000, 1'b0);
    tick(4'hF, 4'b0000, 4'b0100, 1'b0);
    chk("en drop retrigger pass", 32'(pso[0]), 32'h4);

    // clr on the failing edge
    tick(4'hF, 4'b1000, 4'b0000, 1'b0);
    repeat (3) tick(4'hF, 4'b0000, 4'b0000, 1'b0);
    tick(4'hF, 4'b0000, 4'b0000, 1'b1);
    chk("clr fail pulse", 32'(flo[0]), 32'h8);
    chk("clr err", 32'(ers[0][3]), 32'h0);
    chk("clr fail_cnt", 32'(fc0[7:6]), 32'h0);

    repeat (3) tick(4'hF, 4'b0000, 4'b0000, 1'b0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/impl_window_chk.md
# impl_window_chk

Synthesizable, multi-channel runtime checker for the implication `a |-> ##[MIN_DLY:MAX_DLY] b`. It is the hardware counterpart of the simple `a |-> b` assertions used in simulation-only benches. Each channel tracks one outstanding antecedent, times the consequent window, and reports pass/fail pulses, sticky error flags and saturating failure counts. It sits beside the design under check on the same default clock, for use in emulation and FPGA builds where concurrent assertions are unavailable.

## Interface
- NUM_CH, 4, number of independent channels (>=1)
- MIN_DLY, 1, earliest cycle after trigger at which b satisfies (>=0)
- MAX_DLY, 4, last cycle after trigger at which b satisfies (>=MIN_DLY)
- EARLY_FAIL, 0, 1 = b seen before MIN_DLY is a failure; 0 = ignored
- CNT_W, 8, width of per-channel failure counter
---
- clk  in  1  sole clock; all sampling on posedge
- rst_n  in  1  asynchronous, active-low reset
- en  in  NUM_CH  per-channel enable; channel disabled = idle, no triggers
- clr  in  1  synchronous clear of sticky flags and counters
- a  in  NUM_CH  antecedent per channel
- b  in  NUM_CH  consequent per channel
- pass_o  out  NUM_CH  one-cycle pass pulse
- fail_o  out  NUM_CH  one-cycle fail pulse
- err_sticky  out  NUM_CH  set on any fail, held until clr
- busy_o  out  NUM_CH  channel has an outstanding antecedent
- fail_cnt  out  NUM_CH*CNT_W  per-channel failures, channel i at [i*CNT_W +: CNT_W], saturating
- ovl_cnt  out  NUM_CH*CNT_W  per-channel antecedents dropped while busy, saturating

## Operation
- Per-channel FSM: IDLE, WAIT.
- IDLE: at an edge with en[i]=1 and a[i]=1, that edge is the trigger (offset 0).
  - If MIN_DLY=0 and b[i]=1 at that edge: pass, stay IDLE.
  - If MAX_DLY=0 and b[i]=0: fail, stay IDLE.
  - Otherwise go to WAIT with dly=1.
- WAIT: each edge evaluates b[i] at offset dly:
  - dly in [MIN_DLY, MAX_DLY] and b[i]=1: pass -> IDLE.
  - dly<MIN_DLY and b[i]=1 and EARLY_FAIL=1: fail -> IDLE.
  - dly=MAX_DLY and b[i]=0: fail -> IDLE.
  - Otherwise dly+1.
- a[i]=1 at any edge where the channel is in WAIT, including the resolving edge, increments ovl_cnt[i] and does not retrigger. No pipelined overlapping attempts.
- Deasserting en[i] in WAIT aborts the attempt: channel goes to IDLE with no pulse.
- Counters saturate at 2^CNT_W-1 and never wrap.
- clr at the same edge as a fail: clr wins for err_sticky and fail_cnt. The fail_o pulse still fires.
- Delay counter width is $clog2(MAX_DLY+1), minimum 1.

## Timing
- Outputs are registered. A pass/fail decided at edge k is visible on pass_o/fail_o during the cycle after edge k, for exactly one cycle.
- pass_o and fail_o are never both high on the same channel.
- busy_o is high in every cycle where state=WAIT.
- Latency from trigger to fail pulse is MAX_DLY edges + 1 register stage, or earlier under EARLY_FAIL.
- Reset (async assert, sync deassert internally by the caller):
  - state IDLE, dly 0.
  - pass_o, fail_o, busy_o, err_sticky, fail_cnt, ovl_cnt all 0.
- Reset mid-WAIT discards the attempt with no pulse.
- Channels are fully independent; simultaneous events on different channels never interact.

## Structure
- Package impl_window_chk_pkg:
  - chk_state_e enum (IDLE, WAIT).
  - Saturating-increment function.
  - Parameter legality checks (MAX_DLY>=MIN_DLY) as elaboration-time $error.
- Sub-module impl_window_chk_chan holds one channel: FSM, delay counter, two saturating counters, registered outputs.
- The top generates NUM_CH instances and packs their outputs.

## Test plan
- MIN_DLY=1, MAX_DLY=4; a[0] pulse at edge 2, b[0] at edge 5 -> pass_o[0] high one cycle after edge 5; fail_cnt[0]=0.
- Same parameters; a[1] at edge 2, b[1] never -> fail_o[1] after edge 6; err_sticky[1]=1; fail_cnt[1]=1; busy_o[1] high edges 2..6 then low.
- EARLY_FAIL=1, MIN_DLY=2: a at edge 0, b at edge 1 -> fail at edge 1. Repeat with EARLY_FAIL=0 and b at edges 1 and 3 -> pass at edge 3.
- a held high 10 cycles with MAX_DLY=4 and b never -> two fails, ovl_cnt incremented on each non-trigger busy edge; with CNT_W=2, counters stick at 3.
- MIN_DLY=0, MAX_DLY=0: a=b=1 same edge -> pass with zero wait; a=1, b=0 -> immediate fail.
- rst_n low mid-WAIT, or en[i] dropped mid-WAIT -> no pulse, channel IDLE, next trigger behaves normally. clr coincident with fail -> fail_o pulses, sticky and count stay 0.
